// File: rtl/uart_tx_if.sv
// Handshake bundle between command logic and the UART transmitter.
// The master side strobes a byte in; the slave side drives the line and status.
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       busy;
  logic       tx_done;

  modport master (output trmt, output tx_data, input TX, input busy, input tx_done);
  modport slave  (input trmt, input tx_data, output TX, output busy, output tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first, each bit held BAUDC+1 clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
  parameter logic [11:0] BAUDC = 12'hA2B
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XMIT = 2'b01
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [11:0]             r_baud_cnt;
  logic [3:0]              r_bit_cnt;
  logic [FRAME_BITS-1:0]   r_shift_reg;
  logic [FRAME_BITS-1:0]   w_frame;
  logic                    r_busy;
  logic                    r_tx_done;
  logic                    w_accept;
  logic                    w_shift;
  logic                    w_last;

  always_comb begin
`ifdef UART_TX_PARITY_EN
    w_frame = {1'b1, ^bus.tx_data, bus.tx_data, 1'b0};
`else
    w_frame = {1'b1, bus.tx_data, 1'b0};
`endif
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept    = bus.trmt;
        w_state_nxt = bus.trmt ? XMIT : IDLE;
      end
      XMIT: begin
        w_shift     = (r_baud_cnt == BAUDC);
        w_last      = w_shift && (r_bit_cnt == LAST_BIT);
        w_state_nxt = w_last ? IDLE : XMIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stop bit and idle level both come from the ones shifted in at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift_reg <= '1;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
    end else if (w_accept) begin
      r_shift_reg <= w_frame;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tx_done   <= 1'b0;
      r_busy      <= 1'b1;
    end else if (r_state == XMIT) begin
      if (w_shift) begin
        r_baud_cnt  <= '0;
        r_shift_reg <= {1'b1, r_shift_reg[FRAME_BITS-1:1]};
        r_bit_cnt   <= r_bit_cnt + 4'd1;
        if (w_last) begin
          r_busy    <= 1'b0;
          r_tx_done <= 1'b1;
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 12'd1;
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign bus.TX      = r_shift_reg[0];
  assign bus.busy    = r_busy;
  assign bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUDC=15 (16 clocks per bit).
// Outputs are logged on falling edges; sample 0 is the half cycle after the accept edge.
module tb_uart_tx;
  localparam logic [11:0] BAUDC = 12'd15;
  localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic tx_log   [0:399];
  logic busy_log [0:399];
  logic done_log [0:399];

  uart_tx_if bus();
  uart_tx #(.BAUDC(BAUDC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, 1'b1, d, 1'b0};
`endif
  endfunction

  // Call at a falling edge; returns at the falling edge after the accept edge.
  task automatic start_frame(input logic [7:0] d);
    bus.tx_data = d;
    bus.trmt    = 1'b1;
    @(negedge clk);
    bus.trmt    = 1'b0;
    bus.tx_data = ~d;
  endtask

  // Logs n samples; optionally pulses trmt (data 8'h3C) at samples p0/p1.
  task automatic capture(input int n, input int p0, input int p1);
    for (int i = 0; i < n; i++) begin
      tx_log[i]   = bus.TX;
      busy_log[i] = bus.busy;
      done_log[i] = bus.tx_done;
      if (i == p0 || i == p1) begin
        bus.trmt    = 1'b1;
        bus.tx_data = 8'h3C;
      end else begin
        bus.trmt = 1'b0;
      end
      @(negedge clk);
    end
    bus.trmt = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;
    @(negedge clk);
    checks++;
    if ({bus.TX, bus.busy, bus.tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: TX/busy/done=%b expected 100", {bus.TX, bus.busy, bus.tx_done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({bus.TX, bus.busy, bus.tx_done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle[%0d]: TX/busy/done=%b expected 100", i, {bus.TX, bus.busy, bus.tx_done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_send_a5();
    logic [10:0] exp;
    logic bad;
    logic act;
    exp = exp_frame(8'hA5);
    start_frame(8'hA5);
    capture(FRAME + 10, -1, -1);
    for (int k = 0; k < NB; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL a5_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    bad = 1'b0;
    for (int i = 0; i < FRAME; i++) if (busy_log[i] !== 1'b1) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL a5_busy_high: busy dropped inside frame, expected 1 for %0d cycles", FRAME); end
    checks++;
    if (busy_log[FRAME] !== 1'b0) begin errors++; $display("FAIL a5_busy_fall: busy=%b expected 0", busy_log[FRAME]); end
    checks++;
    if (done_log[FRAME-1] !== 1'b0) begin errors++; $display("FAIL a5_done_early: tx_done=%b expected 0", done_log[FRAME-1]); end
    checks++;
    if (done_log[FRAME] !== 1'b1) begin errors++; $display("FAIL a5_done_set: tx_done=%b expected 1", done_log[FRAME]); end
    checks++;
    if (done_log[FRAME+9] !== 1'b1 || tx_log[FRAME+9] !== 1'b1) begin
      errors++;
      $display("FAIL a5_done_held: tx_done/TX=%b%b expected 11", done_log[FRAME+9], tx_log[FRAME+9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp;
    logic bad;
    logic act;
    exp = exp_frame(8'h00);
    start_frame(8'h00);
    capture(FRAME, -1, -1);
    for (int k = 0; k < NB; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL b2b_f1_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    checks++;
    if ({bus.busy, bus.tx_done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_f1_end: busy/done=%b expected 01", {bus.busy, bus.tx_done});
    end
    start_frame(8'hFF);
    checks++;
    if ({bus.TX, bus.busy, bus.tx_done} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_f2_accept: TX/busy/done=%b expected 010", {bus.TX, bus.busy, bus.tx_done});
    end
    exp = exp_frame(8'hFF);
    capture(FRAME + 2, -1, -1);
    for (int k = 0; k < NB; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL b2b_f2_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    checks++;
    if (done_log[FRAME] !== 1'b1) begin errors++; $display("FAIL b2b_f2_done: tx_done=%b expected 1", done_log[FRAME]); end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] exp;
    logic bad;
    logic act;
    exp = exp_frame(8'h81);
    start_frame(8'h81);
    capture(FRAME + 40, 70, FRAME - 1);
    for (int k = 0; k < NB; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL ign_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    bad = 1'b0;
    for (int i = 0; i < FRAME; i++) if (busy_log[i] !== 1'b1) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL ign_busy_high: busy dropped inside frame, expected 1"); end
    for (int i = FRAME; i < FRAME + 40; i++) begin
      checks++;
      if ({tx_log[i], busy_log[i], done_log[i]} !== 3'b101) begin
        errors++;
        $display("FAIL ign_after[%0d]: TX/busy/done=%b expected 101", i, {tx_log[i], busy_log[i], done_log[i]});
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] exp;
    logic bad;
    logic act;
    start_frame(8'h55);
    capture(4*BT + 6, -1, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.TX, bus.busy, bus.tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid: TX/busy/done=%b expected 100", {bus.TX, bus.busy, bus.tx_done});
    end
    capture(20, -1, -1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) if ({tx_log[i], busy_log[i], done_log[i]} !== 3'b100) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL rst_mid_idle: line not idle after abort, expected TX/busy/done=100"); end
    exp = exp_frame(8'h55);
    start_frame(8'h55);
    capture(FRAME + 4, -1, -1);
    for (int k = 0; k < NB; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL rst_resend_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    checks++;
    if ({busy_log[FRAME], done_log[FRAME]} !== 2'b01) begin
      errors++;
      $display("FAIL rst_resend_end: busy/done=%b expected 01", {busy_log[FRAME], done_log[FRAME]});
    end
    rst         = 1'b1;
    bus.trmt    = 1'b1;
    bus.tx_data = 8'h00;
    @(negedge clk);
    rst      = 1'b0;
    bus.trmt = 1'b0;
    checks++;
    if ({bus.TX, bus.busy, bus.tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rst_wins: TX/busy/done=%b expected 100", {bus.TX, bus.busy, bus.tx_done});
    end
    capture(5, -1, -1);
    checks++;
    if ({tx_log[4], busy_log[4]} !== 2'b10) begin
      errors++;
      $display("FAIL rst_wins_idle: TX/busy=%b expected 10", {tx_log[4], busy_log[4]});
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] exp;
    logic bad;
    logic act;
    exp = 11'b11_0000_0111_0;
    start_frame(8'h07);
    capture(FRAME + 2, -1, -1);
    for (int k = 0; k < 11; k++) begin
      bad = 1'b0;
      act = exp[k];
      for (int j = 0; j < BT; j++)
        if (tx_log[k*BT+j] !== exp[k]) begin bad = 1'b1; act = tx_log[k*BT+j]; end
      checks++;
      if (bad) begin errors++; $display("FAIL par_bit%0d: TX=%b expected %b", k, act, exp[k]); end
    end
    checks++;
    if ({busy_log[175], busy_log[176], done_log[176]} !== 3'b101) begin
      errors++;
      $display("FAIL par_len: busy175/busy176/done176=%b expected 101",
               {busy_log[175], busy_log[176], done_log[176]});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_send_a5();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
